// File: rtl/hoplite_router.sv
// hoplite_router: deflection-routed torus router with buffered ejection FIFO and routing statistics.
module hoplite_router #(
  parameter int D_W         = 32,
  parameter int X_AW        = 1,
  parameter int Y_AW        = 1,
  parameter int X_POS       = 0,
  parameter int Y_POS       = 0,
  parameter int EJECT_DEPTH = 4,
  localparam int P_W        = D_W + Y_AW + X_AW
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic [P_W-1:0] xin_pkt,
  input  logic           xin_vld,
  input  logic [P_W-1:0] yin_pkt,
  input  logic           yin_vld,
  input  logic [P_W-1:0] pein_pkt,
  input  logic           pein_vld,
  output logic           pein_rdy,
  output logic [P_W-1:0] xout_pkt,
  output logic           xout_vld,
  output logic [P_W-1:0] yout_pkt,
  output logic           yout_vld,
  output logic [P_W-1:0] ej_pkt,
  output logic           ej_vld,
  input  logic           ej_rdy,
  output logic [31:0]    defl_cnt,
  output logic [31:0]    ej_cnt
);
  localparam int CW = $clog2(EJECT_DEPTH);
  localparam logic [X_AW-1:0] XP = X_POS[X_AW-1:0];
  localparam logic [Y_AW-1:0] YP = Y_POS[Y_AW-1:0];
  logic [P_W-1:0] mem [EJECT_DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW:0] count;
  logic y_ym, x_xm, x_ym, pe_xm, ej_free;
  logic y_push, y_take, x_push, x_to_y, x_to_x, pe_go, push, pop;
  logic y_defl, x_defl;
  assign y_ym  = yin_pkt[X_AW+Y_AW-1:X_AW] == YP;
  assign x_xm  = xin_pkt[X_AW-1:0] == XP;
  assign x_ym  = xin_pkt[X_AW+Y_AW-1:X_AW] == YP;
  assign pe_xm = pein_pkt[X_AW-1:0] == XP;
  // FIFO depth is a power of two, so the count MSB alone flags full
  assign ej_free = ~count[CW];
  always_comb begin
    y_push   = yin_vld & y_ym & ej_free;
    y_take   = yin_vld & ~y_push;
    x_push   = xin_vld & x_xm & x_ym & ej_free & ~y_push;
    x_to_y   = xin_vld & ~x_push & x_xm & ~y_take;
    x_to_x   = xin_vld & ~x_push & ~x_to_y;
    y_defl   = y_take & y_ym;
    x_defl   = x_to_x & x_xm;
    pein_rdy = pe_xm ? ~(y_take | x_to_y) : ~x_to_x;
    pe_go    = pein_vld & pein_rdy;
    push     = y_push | x_push;
    pop      = ej_vld & ej_rdy;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      xout_pkt <= '0;
      xout_vld <= 1'b0;
      yout_pkt <= '0;
      yout_vld <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      defl_cnt <= '0;
      ej_cnt   <= '0;
    end else begin
      xout_vld <= x_to_x | (pe_go & ~pe_xm);
      xout_pkt <= x_to_x ? xin_pkt : pein_pkt;
      yout_vld <= y_take | x_to_y | (pe_go & pe_xm);
      yout_pkt <= y_take ? yin_pkt : x_to_y ? xin_pkt : pein_pkt;
      wr_ptr   <= wr_ptr + CW'(push);
      rd_ptr   <= rd_ptr + CW'(pop);
      count    <= count + (CW+1)'(push) - (CW+1)'(pop);
      defl_cnt <= defl_cnt + 32'(y_defl) + 32'(x_defl);
      ej_cnt   <= ej_cnt + 32'(push);
    end
  end
  always_ff @(posedge ap_clk) if (push) mem[wr_ptr] <= y_push ? yin_pkt : xin_pkt;
  assign ej_vld = count != '0;
  assign ej_pkt = mem[rd_ptr];
endmodule

// File: tb/tb_hoplite_router.sv
// tb_hoplite_router: directed scenario tests for hoplite_router at tile (1,2) on a 4x4 torus.
module tb_hoplite_router;
  localparam int P_W = 36;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic [P_W-1:0] xin_pkt, yin_pkt, pein_pkt, xout_pkt, yout_pkt, ej_pkt;
  logic xin_vld, yin_vld, pein_vld, pein_rdy, xout_vld, yout_vld, ej_vld, ej_rdy;
  logic [31:0] defl_cnt, ej_cnt;
  int n_cmp = 0, n_err = 0;

  hoplite_router #(.D_W(32), .X_AW(2), .Y_AW(2), .X_POS(1), .Y_POS(2), .EJECT_DEPTH(4)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .xin_pkt(xin_pkt), .xin_vld(xin_vld), .yin_pkt(yin_pkt), .yin_vld(yin_vld),
    .pein_pkt(pein_pkt), .pein_vld(pein_vld), .pein_rdy(pein_rdy),
    .xout_pkt(xout_pkt), .xout_vld(xout_vld), .yout_pkt(yout_pkt), .yout_vld(yout_vld),
    .ej_pkt(ej_pkt), .ej_vld(ej_vld), .ej_rdy(ej_rdy),
    .defl_cnt(defl_cnt), .ej_cnt(ej_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [P_W-1:0] mk(input logic [31:0] p, input logic [1:0] x, input logic [1:0] y);
    return {p, y, x};
  endfunction

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle();
    xin_vld = 0; yin_vld = 0; pein_vld = 0; ej_rdy = 0;
    xin_pkt = '0; yin_pkt = '0; pein_pkt = '0;
  endtask

  task automatic test_reset();
    idle();
    #12 ap_rst_n = 1'b1;
    step();
    n_cmp++; if (xout_vld !== 1'b0) begin n_err++; $display("FAIL reset_xout_vld got %b exp 0", xout_vld); end
    n_cmp++; if (yout_vld !== 1'b0) begin n_err++; $display("FAIL reset_yout_vld got %b exp 0", yout_vld); end
    n_cmp++; if (ej_vld !== 1'b0) begin n_err++; $display("FAIL reset_ej_vld got %b exp 0", ej_vld); end
    n_cmp++; if (xout_pkt !== '0) begin n_err++; $display("FAIL reset_xout_pkt got %h exp 0", xout_pkt); end
    n_cmp++; if (defl_cnt !== 0 || ej_cnt !== 0) begin n_err++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", defl_cnt, ej_cnt); end
  endtask

  task automatic test_pass_through();
    xin_vld = 1; xin_pkt = mk(32'hA5A5A5A5, 2'd3, 2'd0);
    step();
    idle();
    n_cmp++; if (xout_vld !== 1'b1) begin n_err++; $display("FAIL pass_xout_vld got %b exp 1", xout_vld); end
    n_cmp++; if (xout_pkt !== mk(32'hA5A5A5A5, 2'd3, 2'd0)) begin n_err++; $display("FAIL pass_xout_pkt got %h exp %h", xout_pkt, mk(32'hA5A5A5A5, 2'd3, 2'd0)); end
    n_cmp++; if (yout_vld !== 1'b0) begin n_err++; $display("FAIL pass_yout_vld got %b exp 0", yout_vld); end
    n_cmp++; if (defl_cnt !== 0) begin n_err++; $display("FAIL pass_defl got %0d exp 0", defl_cnt); end
  endtask

  task automatic test_turn();
    yin_vld = 1; yin_pkt = mk(32'h0000AAAA, 2'd1, 2'd3);
    xin_vld = 1; xin_pkt = mk(32'h0000BBBB, 2'd1, 2'd0);
    step();
    n_cmp++; if (yout_vld !== 1'b1 || yout_pkt !== mk(32'h0000AAAA, 2'd1, 2'd3)) begin n_err++; $display("FAIL turn_conf_yout got %b/%h exp 1/%h", yout_vld, yout_pkt, mk(32'h0000AAAA, 2'd1, 2'd3)); end
    n_cmp++; if (xout_vld !== 1'b1 || xout_pkt !== mk(32'h0000BBBB, 2'd1, 2'd0)) begin n_err++; $display("FAIL turn_conf_xout got %b/%h exp 1/%h", xout_vld, xout_pkt, mk(32'h0000BBBB, 2'd1, 2'd0)); end
    n_cmp++; if (defl_cnt !== 1) begin n_err++; $display("FAIL turn_conf_defl got %0d exp 1", defl_cnt); end
    yin_vld = 0;
    step();
    idle();
    n_cmp++; if (yout_vld !== 1'b1 || yout_pkt !== mk(32'h0000BBBB, 2'd1, 2'd0)) begin n_err++; $display("FAIL turn_free_yout got %b/%h exp 1/%h", yout_vld, yout_pkt, mk(32'h0000BBBB, 2'd1, 2'd0)); end
    n_cmp++; if (xout_vld !== 1'b0) begin n_err++; $display("FAIL turn_free_xout_vld got %b exp 0", xout_vld); end
    n_cmp++; if (defl_cnt !== 1) begin n_err++; $display("FAIL turn_free_defl got %0d exp 1", defl_cnt); end
  endtask

  task automatic test_eject();
    yin_vld = 1; yin_pkt = mk(32'h11111111, 2'd1, 2'd2);
    xin_vld = 1; xin_pkt = mk(32'h22222222, 2'd1, 2'd2);
    step();
    idle();
    n_cmp++; if (yout_vld !== 1'b1 || yout_pkt !== mk(32'h22222222, 2'd1, 2'd2)) begin n_err++; $display("FAIL ej_xin_yout got %b/%h exp 1/%h", yout_vld, yout_pkt, mk(32'h22222222, 2'd1, 2'd2)); end
    n_cmp++; if (xout_vld !== 1'b0) begin n_err++; $display("FAIL ej_xout_vld got %b exp 0", xout_vld); end
    n_cmp++; if (ej_cnt !== 1 || defl_cnt !== 1) begin n_err++; $display("FAIL ej_cnts got ej=%0d defl=%0d exp 1/1", ej_cnt, defl_cnt); end
    n_cmp++; if (ej_vld !== 1'b1 || ej_pkt !== mk(32'h11111111, 2'd1, 2'd2)) begin n_err++; $display("FAIL ej_head got %b/%h exp 1/%h", ej_vld, ej_pkt, mk(32'h11111111, 2'd1, 2'd2)); end
    ej_rdy = 1;
    step();
    ej_rdy = 0;
    n_cmp++; if (ej_vld !== 1'b0) begin n_err++; $display("FAIL ej_drained got %b exp 0", ej_vld); end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      yin_vld = 1; yin_pkt = mk(32'h100 + 32'(i), 2'd1, 2'd2);
      step();
    end
    n_cmp++; if (yout_vld !== 1'b0 || ej_cnt !== 5) begin n_err++; $display("FAIL full_fill got yout_vld=%b ej=%0d exp 0/5", yout_vld, ej_cnt); end
    yin_pkt = mk(32'h104, 2'd1, 2'd2);
    step();
    n_cmp++; if (yout_vld !== 1'b1 || yout_pkt !== mk(32'h104, 2'd1, 2'd2)) begin n_err++; $display("FAIL full_defl_yout got %b/%h exp 1/%h", yout_vld, yout_pkt, mk(32'h104, 2'd1, 2'd2)); end
    n_cmp++; if (defl_cnt !== 2 || ej_cnt !== 5) begin n_err++; $display("FAIL full_cnts got defl=%0d ej=%0d exp 2/5", defl_cnt, ej_cnt); end
    n_cmp++; if (ej_vld !== 1'b1 || ej_pkt !== mk(32'h100, 2'd1, 2'd2)) begin n_err++; $display("FAIL full_head got %b/%h exp 1/%h", ej_vld, ej_pkt, mk(32'h100, 2'd1, 2'd2)); end
    yin_pkt = mk(32'h200, 2'd1, 2'd2);
    ej_rdy = 1;
    step();
    ej_rdy = 0;
    n_cmp++; if (yout_vld !== 1'b1 || defl_cnt !== 3 || ej_cnt !== 5) begin n_err++; $display("FAIL pop_no_reuse got yout_vld=%b defl=%0d ej=%0d exp 1/3/5", yout_vld, defl_cnt, ej_cnt); end
    n_cmp++; if (ej_pkt !== mk(32'h101, 2'd1, 2'd2)) begin n_err++; $display("FAIL pop_head got %h exp %h", ej_pkt, mk(32'h101, 2'd1, 2'd2)); end
    step();
    idle();
    n_cmp++; if (yout_vld !== 1'b0 || defl_cnt !== 3 || ej_cnt !== 6) begin n_err++; $display("FAIL refill got yout_vld=%b defl=%0d ej=%0d exp 0/3/6", yout_vld, defl_cnt, ej_cnt); end
  endtask

  task automatic test_inject();
    pein_vld = 1; pein_pkt = mk(32'hCAFE0001, 2'd2, 2'd0);
    xin_vld = 1; xin_pkt = mk(32'h0000DDDD, 2'd3, 2'd0);
    #1;
    n_cmp++; if (pein_rdy !== 1'b0) begin n_err++; $display("FAIL inj_x_blocked got %b exp 0", pein_rdy); end
    xin_vld = 0;
    #1;
    n_cmp++; if (pein_rdy !== 1'b1) begin n_err++; $display("FAIL inj_x_free got %b exp 1", pein_rdy); end
    step();
    idle();
    n_cmp++; if (xout_vld !== 1'b1 || xout_pkt !== mk(32'hCAFE0001, 2'd2, 2'd0)) begin n_err++; $display("FAIL inj_xout got %b/%h exp 1/%h", xout_vld, xout_pkt, mk(32'hCAFE0001, 2'd2, 2'd0)); end
    pein_vld = 1; pein_pkt = mk(32'hCAFE0002, 2'd1, 2'd0);
    yin_vld = 1; yin_pkt = mk(32'h0000EEEE, 2'd1, 2'd3);
    #1;
    n_cmp++; if (pein_rdy !== 1'b0) begin n_err++; $display("FAIL inj_y_blocked got %b exp 0", pein_rdy); end
    step();
    idle();
    n_cmp++; if (yout_pkt !== mk(32'h0000EEEE, 2'd1, 2'd3) || xout_vld !== 1'b0) begin n_err++; $display("FAIL inj_y_ring got %h/%b exp %h/0", yout_pkt, xout_vld, mk(32'h0000EEEE, 2'd1, 2'd3)); end
  endtask

  task automatic test_reset_midstream();
    ej_rdy = 1;
    xin_vld = 1; xin_pkt = mk(32'h0000F00D, 2'd3, 2'd0);
    step();
    idle();
    n_cmp++; if (ej_vld !== 1'b1 || xout_vld !== 1'b1) begin n_err++; $display("FAIL pre_rst got ej_vld=%b xout_vld=%b exp 1/1", ej_vld, xout_vld); end
    #2 ap_rst_n = 1'b0;
    #1;
    n_cmp++; if (xout_vld !== 1'b0 || yout_vld !== 1'b0 || ej_vld !== 1'b0) begin n_err++; $display("FAIL rst_vlds got x=%b y=%b ej=%b exp 0/0/0", xout_vld, yout_vld, ej_vld); end
    n_cmp++; if (defl_cnt !== 0 || ej_cnt !== 0) begin n_err++; $display("FAIL rst_cnts got %0d/%0d exp 0/0", defl_cnt, ej_cnt); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    step();
    n_cmp++; if (ej_vld !== 1'b0) begin n_err++; $display("FAIL post_rst_ej_vld got %b exp 0", ej_vld); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_turn();
    test_eject();
    test_fifo_full();
    test_inject();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
